// File: rtl/instruction_fetch.sv
// PC generation and fetch buffer between word-addressed instruction memory and decode.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module instruction_fetch #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [ADDR_W-1:0]             pc,
  output logic                          a_valid,
  input  logic                          a_ready,
  input  logic [DATA_W-1:0]             instruction,
  input  logic                          d_ready,
  output logic                          dec_valid,
  output logic [DATA_W-1:0]             dec_instr,
  output logic [ADDR_W-1:0]             dec_pc,
  input  logic                          dec_ready,
  input  logic                          redirect,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]                   perf_fetched,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [DATA_W-1:0]  buf_instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  buf_pc_q    [FIFO_DEPTH];
  logic [ADDR_W-1:0]  tag_q       [FIFO_DEPTH];

  logic rsp_ok, credit_ok, fire, push, pop, buf_we, tag_we;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    a_valid   = 1'b0;
    push      = 1'b0;
    // a response with nothing in flight is a protocol error and is dropped
    rsp_ok    = d_ready && (outst_q != '0);
    credit_ok = ({1'b0, cnt_q} + {1'b0, outst_q}) < DEPTH_X;

    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        a_valid = credit_ok;
        push    = rsp_ok;
      end
      DRAIN: begin
        if (rsp_ok) drop_d = drop_q - CNT_W'(1);
        if (drop_d == '0) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    fire    = a_valid && a_ready;
    pop     = dec_valid && dec_ready;
    outst_d = outst_q + CNT_W'(fire) - CNT_W'(rsp_ok);
    if (fire) begin
      pc_d     = pc_q + ADDR_W'(1);
      tag_wr_d = tag_wr_q + PTR_W'(1);
    end
    if (push) begin
      wr_d     = wr_q + PTR_W'(1);
      tag_rd_d = tag_rd_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    buf_we = push && !redirect;
    tag_we = fire && !redirect;

    // every in-flight response, including one fired this cycle, belongs to the old path
    if (redirect) begin
      pc_d     = redirect_pc;
      drop_d   = outst_d;
      cnt_d    = '0;
      wr_d     = '0;
      rd_d     = '0;
      tag_wr_d = '0;
      tag_rd_d = '0;
      state_d  = (outst_d != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  // storage arrays need no reset; validity comes from the pointers and counts
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[tag_wr_q] <= pc_q;
    if (buf_we) begin
      buf_instr_q[wr_q] <= instruction;
      buf_pc_q[wr_q]    <= tag_q[tag_rd_q];
    end
  end

  assign pc         = pc_q;
  assign fifo_count = cnt_q;
  assign dec_valid  = (cnt_q != '0);
  assign dec_instr  = dec_valid ? buf_instr_q[rd_q] : '0;
  assign dec_pc     = dec_valid ? buf_pc_q[rd_q]    : '0;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_cyc;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    stall_cyc      = ((state_q == FETCH) && !fire) || (state_q == DRAIN);
    if (pop && !redirect && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
    if (stall_cyc && (perf_stall_q != '1))          perf_stall_d   = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: in-order memory model plus a decode-side sequence scoreboard.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        a_valid, a_ready;
  logic [31:0] instruction;
  logic        d_ready;
  logic        dec_valid;
  logic [31:0] dec_instr, dec_pc;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic        resp_en;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .a_valid(a_valid), .a_ready(a_ready),
    .instruction(instruction), .d_ready(d_ready), .dec_valid(dec_valid),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fifo_count(fifo_count)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory: accepts addresses in order, answers one cycle later unless resp_en holds it off
  logic [31:0] rq_addr [64];
  logic [5:0]  rq_wr = 6'd0;
  logic [5:0]  rq_rd = 6'd0;
  assign d_ready     = resp_en && (rq_wr != rq_rd);
  assign instruction = mem_word(rq_addr[rq_rd]);

  always @(posedge clk) begin
    if (a_valid && a_ready) begin
      rq_addr[rq_wr] <= pc;
      rq_wr          <= rq_wr + 6'd1;
    end
    if (d_ready) rq_rd <= rq_rd + 6'd1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // every word decode takes must be the next address in program order
  task automatic tick();
    if (dec_valid && dec_ready && !redirect && !reset) begin
      chk("pop_pc", dec_pc, exp_pc);
      chk("pop_instr", dec_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_avalid"}, a_valid, 1'b0);
    chk({tag, "_dvalid"}, dec_valid, 1'b0);
    chk({tag, "_dinstr"}, dec_instr, 32'h0);
    chk({tag, "_dpc"}, dec_pc, 32'h0);
    chk({tag, "_count"}, fifo_count, 3'd0);
  endtask

  initial begin
    logic [6:0] credit;
    reset = 1'b1; a_ready = 1'b1; resp_en = 1'b1; dec_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; exp_pc = 32'h0;
    tick(); tick();
    chk_reset_state("rst");

    // streaming from reset
    reset = 1'b0;
    tick();
    chk("idle_exit_avalid", a_valid, 1'b1);
    chk("idle_exit_dvalid", dec_valid, 1'b0);
    tick();
    chk("lat2_dvalid", dec_valid, 1'b0);
    tick();
    chk("lat3_dvalid", dec_valid, 1'b1);
    chk("first_dpc", dec_pc, 32'h0);
    chk("first_instr", dec_instr, mem_word(32'h0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_dpc", dec_pc, 32'(i + 1));
    end

    // decode backpressure
    dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      credit = {4'd0, fifo_count} + {1'b0, 6'(rq_wr - rq_rd)};
      chk("credit", credit <= 7'd4, 1'b1);
    end
    chk("bp_full", fifo_count, 3'd4);
    chk("bp_avalid", a_valid, 1'b0);
    chk("bp_head", dec_pc, exp_pc);
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // address stall: everything drains and pc waits at the next unfetched word
    a_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("stall_pc", pc, exp_pc);
    chk("stall_avalid", a_valid, 1'b1);
    chk("stall_count", fifo_count, 3'd0);
    a_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    a_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("drain_pc", pc, exp_pc);

    // redirect with two requests in flight
    resp_en = 1'b0; a_ready = 1'b1;
    tick(); tick();
    a_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    chk("redir_pc", pc, 32'h20);
    chk("redir_avalid", a_valid, 1'b0);
    chk("redir_count", fifo_count, 3'd0);
    resp_en = 1'b1; a_ready = 1'b1; exp_pc = 32'h20;
    tick();
    chk("drop1_avalid", a_valid, 1'b0);
    chk("drop1_dvalid", dec_valid, 1'b0);
    tick();
    chk("drop2_avalid", a_valid, 1'b1);
    chk("drop2_pc", pc, 32'h20);
    chk("drop2_dvalid", dec_valid, 1'b0);
    tick();
    chk("redir_lat_dvalid", dec_valid, 1'b0);
    tick();
    chk("redir_dvalid", dec_valid, 1'b1);
    chk("redir_dpc", dec_pc, 32'h20);
    chk("redir_instr", dec_instr, mem_word(32'h20));
    for (int i = 0; i < 6; i++) tick();

    // redirect while streaming, across the address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0; exp_pc = 32'hFFFF_FFFF;
    chk("wrap_flush", dec_valid, 1'b0);
    for (int i = 0; i < 10 && !dec_valid; i++) tick();
    chk("wrap_timeout", dec_valid, 1'b1);
    chk("wrap_dpc0", dec_pc, 32'hFFFF_FFFF);
    tick();
    chk("wrap_dpc1", dec_pc, 32'h0);
    chk("wrap_instr1", dec_instr, mem_word(32'h0));
    for (int i = 0; i < 4; i++) tick();

    // mid-run reset with three words queued and one stale response pending
    a_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    dec_ready = 1'b0; a_ready = 1'b1;
    tick(); tick(); tick();
    a_ready = 1'b0;
    tick();
    chk("pre_rst_count", fifo_count, 3'd3);
    resp_en = 1'b0; a_ready = 1'b1;
    tick();
    chk("pre_rst_full", a_valid, 1'b0);
    reset = 1'b1; a_ready = 1'b0;
    tick();
    chk_reset_state("mid_rst");
    reset = 1'b0; resp_en = 1'b1; a_ready = 1'b1; dec_ready = 1'b1; exp_pc = 32'h0;
    tick();
    chk("stale_count", fifo_count, 3'd0);
    chk("stale_dvalid", dec_valid, 1'b0);
    tick();
    chk("post_rst_lat", dec_valid, 1'b0);
    tick();
    chk("post_rst_dvalid", dec_valid, 1'b1);
    chk("post_rst_dpc", dec_pc, 32'h0);
    chk("post_rst_instr", dec_instr, mem_word(32'h0));
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_progress", exp_pc, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- PC generation and fetch-buffer stage sitting between the word-addressed instruction memory and the processor decode stage.
- Issues sequential word addresses on pc with an address handshake, collects returned instruction words into an in-order FIFO, and presents them to decode with valid/ready.
- Handles redirects (branch/jump) by flushing buffered words and discarding stale in-flight responses.

Parameters:
- ADDR_W, 32, width of pc / redirect_pc.
- DATA_W, 32, instruction word width.
- FIFO_DEPTH, 4, fetch buffer entries (power of 2, >=2).
- RESET_PC, 0, pc value loaded on reset.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc  output  ADDR_W  fetch word address to instruction memory
- a_valid  output  1  pc is a valid fetch request this cycle
- a_ready  input  1  memory accepts address; request fires when a_valid & a_ready
- instruction  input  DATA_W  returned instruction word
- d_ready  input  1  instruction holds a valid response this cycle; responses return in request order
- dec_valid  output  1  dec_instr/dec_pc valid
- dec_instr  output  DATA_W  FIFO head instruction
- dec_pc  output  ADDR_W  address of dec_instr
- dec_ready  input  1  decode consumes head when dec_valid & dec_ready
- redirect  input  1  one-cycle redirect request
- redirect_pc  input  ADDR_W  new fetch address
- fifo_count  output  clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (reset high at rising edge): pc=RESET_PC, a_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, fifo_count=0, outstanding=0, drop_cnt=0, state=IDLE. Reset mid-operation discards everything; responses arriving after reset are ignored until the first post-reset request fires.
- FSM:
  - IDLE: one cycle after reset, a_valid=0; next FETCH.
  - FETCH: a_valid = (fifo_count + outstanding < FIFO_DEPTH). On fire, pc <= pc+1 and outstanding++.
  - DRAIN: a_valid=0. Each d_ready decrements drop_cnt and the word is discarded; go to FETCH when drop_cnt reaches 0, including the cycle it reaches 0.
- Credit rule: fifo_count + outstanding never exceeds FIFO_DEPTH, so a response never meets a full FIFO.
- Response handling in FETCH: d_ready pushes {instruction, tag pc} into the FIFO and decrements outstanding. Tag pc comes from an internal in-order address queue of depth FIFO_DEPTH. A request fire and a d_ready in the same cycle leave outstanding unchanged.
- Output path: dec_* is driven combinationally from the FIFO head; dec_valid = (fifo_count != 0). Decode latency is 1 cycle: a response captured at edge N is visible on dec_* after edge N.
- Simultaneous push and pop: fifo_count unchanged.
- Pop and wrap-around: read/write pointers wrap modulo FIFO_DEPTH.
- Redirect (highest priority after reset), at the edge where redirect=1:
  - pc <= redirect_pc; FIFO flushed (fifo_count=0, dec_valid=0 next cycle); any same-cycle pop is ignored.
  - drop_cnt <= outstanding − (d_ready ? 1 : 0) + (request fire this cycle ? 1 : 0).
  - Next state = DRAIN if that value is > 0, else FETCH.
  - A redirect during DRAIN reloads pc and recomputes drop_cnt the same way.
- pc arithmetic is modulo 2^ADDR_W; 0xFFFFFFFF+1 = 0.
- d_ready with no outstanding request (protocol error) is ignored.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32-bit, counts FIFO pops) and perf_stall (32-bit, counts cycles in FETCH with a_valid=0 or a_ready=0, plus all DRAIN cycles). Both reset to 0, saturate at 0xFFFFFFFF, and are unaffected by redirect.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Streaming: reset release, a_ready=d_ready=1, memory returns memory[pc] one cycle later, dec_ready=1 -> dec_pc = 0,1,2,3... on consecutive cycles, dec_instr matches memory, first dec_valid 3 cycles after reset deasserts.
- Backpressure: dec_ready=0 for 10 cycles -> fifo_count holds at 4, fifo_count+outstanding <= 4, a_valid=0 while full; on release, no word is lost or duplicated.
- Address stall: a_ready=0 for cycles 5–9 -> pc holds, a_valid stays 1, fetch resumes at the same pc.
- Redirect with 2 in flight: redirect_pc=0x20 -> FSM enters DRAIN, the next 2 responses are dropped, and the first dec_pc after redirect is 0x20 with memory[0x20].
- Wrap and mid-run reset: redirect_pc=0xFFFFFFFF -> dec_pc sequence 0xFFFFFFFF, 0x0. Then reset asserted with 3 words queued -> dec_valid=0 and pc=RESET_PC the next cycle, and stale responses are ignored.
